// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and constants for the ROM arbiter
package rom_arb_pkg;

    localparam int ROM_WORDS_DEF = 256;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } port_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Out-of-range or misaligned byte address
    function automatic logic addr_fault(input logic [31:0] addr, input logic [32:0] limit);
        return ({1'b0, addr} >= limit) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// rtl/rom_arb_pick.sv - combinational one-hot grant picker (bit0 fetch, bit1 load)
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic       if_valid,
    input  logic       ld_valid,
    input  port_e      ptr,
    output logic [1:0] grant
);

    // On contention the port that was not granted last wins; ptr tied to fetch gives load priority
    always_comb begin
        grant = 2'b00;
        if (if_valid && ld_valid) begin
            grant = (ptr == PORT_LD) ? 2'b01 : 2'b10;
        end else if (ld_valid) begin
            grant = 2'b10;
        end else if (if_valid) begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port arbiter for a synchronous ROM; ROM_ARB_RR_EN selects round-robin
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ROM_WORDS = ROM_WORDS_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ld_req_valid,
    output logic        ld_req_ready,
    input  logic [31:0] ld_req_addr,
    output logic        ld_rsp_valid,
    input  logic        ld_rsp_ready,
    output logic [31:0] ld_rsp_data,
    output logic        ld_rsp_err,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_rd
);

    localparam logic [0:0]  S_IDLE     = ST_IDLE;
    localparam logic [0:0]  S_RESP     = ST_RESP;
    localparam logic [32:0] ADDR_LIMIT = 33'(ROM_WORDS * 4);

    logic [0:0]  state_q;
    port_e       owner_q;
    logic        err_q;
    logic [31:0] rom_a_q;

    port_e       ptr;
    logic [1:0]  grant;
    logic        rsp_done;
    logic        can_accept;
    logic        accept;
    port_e       grant_port;
    logic [31:0] grant_addr;

`ifdef ROM_ARB_RR_EN
    port_e ptr_q;

    // Remember the last granted port so the other one wins the next tie
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= PORT_IF;
        end else if (accept) begin
            ptr_q <= grant_port;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = PORT_IF;
`endif

    rom_arb_pick u_pick (
        .if_valid (if_req_valid),
        .ld_valid (ld_req_valid),
        .ptr      (ptr),
        .grant    (grant)
    );

    assign rsp_done   = (state_q == S_RESP) &&
                        ((owner_q == PORT_LD) ? ld_rsp_ready : if_rsp_ready);
    assign can_accept = RST_N && ((state_q == S_IDLE) || rsp_done);

    assign if_req_ready = can_accept && grant[0];
    assign ld_req_ready = can_accept && grant[1];
    assign accept       = if_req_ready || ld_req_ready;

    assign grant_port = grant[1] ? PORT_LD : PORT_IF;
    assign grant_addr = grant[1] ? ld_req_addr : if_req_addr;

    // A new accept steers the ROM immediately; otherwise hold so rom_rd stays stable under backpressure
    assign rom_a = accept ? grant_addr : rom_a_q;

    // Single outstanding response: owner, fault flag and issued address captured at accept
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            owner_q <= PORT_IF;
            err_q   <= 1'b0;
            rom_a_q <= '0;
        end else if (accept) begin
            state_q <= S_RESP;
            owner_q <= grant_port;
            err_q   <= addr_fault(grant_addr, ADDR_LIMIT);
            rom_a_q <= grant_addr;
        end else if (rsp_done) begin
            state_q <= S_IDLE;
        end
    end

    assign if_rsp_valid = (state_q == S_RESP) && (owner_q == PORT_IF);
    assign ld_rsp_valid = (state_q == S_RESP) && (owner_q == PORT_LD);
    assign if_rsp_err   = if_rsp_valid && err_q;
    assign ld_rsp_err   = ld_rsp_valid && err_q;
    assign if_rsp_data  = (if_rsp_valid && !err_q) ? rom_rd : '0;
    assign ld_rsp_data  = (ld_rsp_valid && !err_q) ? rom_rd : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ld_req_valid, ld_req_ready, ld_rsp_valid, ld_rsp_ready, ld_rsp_err;
    logic [31:0] ld_req_addr, ld_rsp_data;
    logic [31:0] rom_a;
    logic [31:0] rom_rd = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ld;
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[7];

    always #5 CLK = ~CLK;

    rom_arbiter dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_req_addr  (ld_req_addr),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_ready (ld_rsp_ready),
        .ld_rsp_data  (ld_rsp_data),
        .ld_rsp_err   (ld_rsp_err),
        .rom_a        (rom_a),
        .rom_rd       (rom_rd)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        w = {24'd0, a[9:2]};
        return (w == 0) ? 32'h00100F93 : 32'h10000000 + w * 32'h101;
    endfunction

    // Synchronous ROM: registers the addressed word every posedge
    always @(posedge CLK) rom_rd <= rom_word(rom_a);

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        logic exp_ld;

        vecs[0] = '{1'b0, 32'h0000_0000, 1'b0, 32'h00100F93};
        vecs[1] = '{1'b1, 32'h0000_0400, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b1, 32'h0000_0006, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, 32'h0000_03FC, 1'b0, 32'h1000FFFF};
        vecs[4] = '{1'b1, 32'h0000_0010, 1'b0, 32'h10000404};
        vecs[5] = '{1'b0, 32'h0000_0401, 1'b1, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000};

        RST_N        = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        ld_req_valid = 1'b1;
        ld_req_addr  = 32'h44;
        if_rsp_ready = 1'b1;
        ld_rsp_ready = 1'b1;
        tick;
        tick;
        #1;
        chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_req_ready}, 32'd0);
        chk("rst_if_valid", {31'd0, if_rsp_valid}, 32'd0);
        chk("rst_ld_valid", {31'd0, ld_rsp_valid}, 32'd0);
        chk("rst_errs", {30'd0, if_rsp_err, ld_rsp_err}, 32'd0);
        chk("rst_rom_a", rom_a, 32'd0);
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        RST_N        = 1'b1;

        // Single transactions from idle, starting in the first cycle after release
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].ld) begin
                ld_req_valid = 1'b1;
                ld_req_addr  = vecs[i].addr;
            end else begin
                if_req_valid = 1'b1;
                if_req_addr  = vecs[i].addr;
            end
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, vecs[i].ld ? ld_req_ready : if_req_ready}, 32'd1);
            chk($sformatf("v%0d_rom_a", i), rom_a, vecs[i].addr);
            tick;
            if_req_valid = 1'b0;
            ld_req_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i), {30'd0, ld_rsp_valid, if_rsp_valid},
                vecs[i].ld ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_data", i), vecs[i].ld ? ld_rsp_data : if_rsp_data, vecs[i].data);
            chk($sformatf("v%0d_err", i), {31'd0, vecs[i].ld ? ld_rsp_err : if_rsp_err},
                {31'd0, vecs[i].err});
            tick;
        end

        // Simultaneous requests: load first, fetch back-to-back
        if_req_valid = 1'b1; if_req_addr = 32'h4;
        ld_req_valid = 1'b1; ld_req_addr = 32'h8;
        #1;
        chk("sim_ld_ready", {30'd0, ld_req_ready, if_req_ready}, 32'd2);
        chk("sim_rom_a0", rom_a, 32'h8);
        tick;
        ld_req_valid = 1'b0;
        #1;
        chk("sim_ld_rsp", {30'd0, ld_rsp_valid, if_rsp_valid}, 32'd2);
        chk("sim_ld_data", ld_rsp_data, 32'h10000202);
        chk("sim_if_ready", {31'd0, if_req_ready}, 32'd1);
        chk("sim_rom_a1", rom_a, 32'h4);
        tick;
        if_req_valid = 1'b0;
        #1;
        chk("sim_if_rsp", {30'd0, ld_rsp_valid, if_rsp_valid}, 32'd1);
        chk("sim_if_data", if_rsp_data, 32'h10000101);
        tick;

        // Continuous contention for six cycles
        if_req_valid = 1'b1; if_req_addr = 32'h24;
        ld_req_valid = 1'b1; ld_req_addr = 32'h20;
        for (int k = 0; k < 6; k++) begin
`ifdef ROM_ARB_RR_EN
            exp_ld = (k % 2 == 0);
`else
            exp_ld = 1'b1;
`endif
            #1;
            chk($sformatf("cont%0d_grant", k), {30'd0, ld_req_ready, if_req_ready},
                exp_ld ? 32'd2 : 32'd1);
            chk($sformatf("cont%0d_rom_a", k), rom_a, exp_ld ? 32'h20 : 32'h24);
            tick;
            #1;
            chk($sformatf("cont%0d_rsp", k), {30'd0, ld_rsp_valid, if_rsp_valid},
                exp_ld ? 32'd2 : 32'd1);
            chk($sformatf("cont%0d_data", k), exp_ld ? ld_rsp_data : if_rsp_data,
                exp_ld ? 32'h10000808 : 32'h10000909);
        end
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        tick;

        // Load response stalled for three cycles with a fetch waiting
        ld_req_valid = 1'b1; ld_req_addr = 32'hC;
        tick;
        ld_req_valid = 1'b0;
        ld_rsp_ready = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h14;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall%0d_valid", s), {31'd0, ld_rsp_valid}, 32'd1);
            chk($sformatf("stall%0d_data", s), ld_rsp_data, 32'h10000303);
            chk($sformatf("stall%0d_rom_a", s), rom_a, 32'hC);
            chk($sformatf("stall%0d_ready", s), {30'd0, ld_req_ready, if_req_ready}, 32'd0);
            tick;
        end
        ld_rsp_ready = 1'b1;
        #1;
        chk("stall_if_ready", {30'd0, ld_req_ready, if_req_ready}, 32'd1);
        chk("stall_rom_a", rom_a, 32'h14);
        tick;
        if_req_valid = 1'b0;
        #1;
        chk("stall_if_rsp", {30'd0, ld_rsp_valid, if_rsp_valid}, 32'd1);
        chk("stall_if_data", if_rsp_data, 32'h10000505);
        tick;

        // Reset while a response is outstanding
        ld_req_valid = 1'b1; ld_req_addr = 32'h8;
        tick;
        ld_req_valid = 1'b0;
        ld_rsp_ready = 1'b0;
        #1;
        chk("mr_pre_valid", {31'd0, ld_rsp_valid}, 32'd1);
        RST_N        = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        #1;
        chk("mr_valid_drop", {30'd0, ld_rsp_valid, if_rsp_valid}, 32'd0);
        chk("mr_ready", {30'd0, ld_req_ready, if_req_ready}, 32'd0);
        chk("mr_rom_a", rom_a, 32'd0);
        tick;
        if_req_valid = 1'b0;
        RST_N        = 1'b1;
        ld_rsp_ready = 1'b1;
        #1;
        chk("mr_post0", {30'd0, ld_rsp_valid, if_rsp_valid}, 32'd0);
        tick;
        #1;
        chk("mr_post1", {30'd0, ld_rsp_valid, if_rsp_valid}, 32'd0);
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        #1;
        chk("mr_new_ready", {31'd0, if_req_ready}, 32'd1);
        tick;
        if_req_valid = 1'b0;
        #1;
        chk("mr_new_valid", {31'd0, if_rsp_valid}, 32'd1);
        chk("mr_new_data", if_rsp_data, 32'h00100F93);
        chk("mr_new_err", {31'd0, if_rsp_err}, 32'd0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ROM_WORDS, default 256, ROM depth in 32-bit words; byte address limit = ROM_WORDS*4.
REQ-002 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-003 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-004 if_req_valid / if_req_ready  in / out  1  fetch request handshake.
REQ-005 if_req_addr  in  32  fetch byte address.
REQ-006 if_rsp_valid / if_rsp_ready  out / in  1  fetch response handshake.
REQ-007 if_rsp_data  out  32  fetch word; if_rsp_err  out  1  fetch address fault.
REQ-008 ld_req_valid, ld_req_ready, ld_req_addr, ld_rsp_valid, ld_rsp_ready, ld_rsp_data, ld_rsp_err: same widths and directions as the fetch set, for the load port.
REQ-009 rom_a  out  32  byte address to the synchronous ROM, which registers the addressed word on each posedge.
REQ-010 rom_rd  in  32  ROM read data, valid one cycle after rom_a is sampled.

Function
REQ-011 States: IDLE (no response outstanding) and RESP (one response outstanding, owner recorded); at most one outstanding response.
REQ-012 A request is accepted on a posedge where req_valid && req_ready; accepted address drives rom_a combinationally in that cycle.
REQ-013 req_ready of the granted port SHALL be 1 when in IDLE, or in RESP with the outstanding response accepted this cycle; otherwise 0; non-granted port ready = 0.
REQ-014 Accept moves to RESP with owner = granted port; rsp_valid of owner asserts the following cycle; latency is exactly 1 cycle.
REQ-015 Response accepted (rsp_valid && rsp_ready) with no new accept -> IDLE; with a new accept -> stay in RESP with the new owner (back-to-back, 1 word/cycle).
REQ-016 While no new request is accepted, rom_a SHALL hold the last issued address so rom_rd stays stable under rsp_ready low.
REQ-017 rsp_data = rom_rd when no fault; a non-owner port SHALL keep rsp_valid = 0.
REQ-018 Fault: addr >= ROM_WORDS*4 or addr[1:0] != 0 -> rsp_err = 1, rsp_data = 0, same latency; the fault flag is registered at accept.
REQ-019 Default arbitration: fixed priority, load over fetch.
REQ-020 Requesters hold valid and addr until accepted; the arbiter does not buffer unaccepted requests.

Reset
REQ-021 RST_N low -> state IDLE, both rsp_valid 0, both rsp_err 0, rom_a 0, round-robin pointer = fetch; all req_ready 0 while RST_N low.
REQ-022 Reset mid-RESP drops the outstanding response; no response is issued after release.
REQ-023 After release, the first request may be accepted in the first cycle.

Configuration
REQ-024 Macro ROM_ARB_RR_EN defined: round-robin; when both request, the port not granted last wins; the pointer updates only on accept.
REQ-025 Macro ROM_ARB_RR_EN undefined: fixed priority per REQ-019, no pointer flop.

Structure
REQ-026 Package rom_arb_pkg holds typedef enum port_e {PORT_IF, PORT_LD}, the state enum, and constant ROM_WORDS_DEF = 256.
REQ-027 One sub-module, rom_arb_pick: a combinational grant picker taking both valids and the pointer and returning a one-hot grant.

Verification
REQ-028 Fetch-only: ROM word0 = 0x00100F93, if_req addr 0x0 -> rom_a = 0x0 same cycle; if_rsp_valid next cycle with data 0x00100F93, err 0.
REQ-029 Simultaneous if/ld at addr 0x4/0x8, fixed priority -> ld granted first, fetch the next cycle; responses on consecutive cycles.
REQ-030 ROM_ARB_RR_EN, both ports requesting continuously for 6 cycles -> grants alternate LD, IF, LD, IF, LD, IF (pointer starts at fetch).
REQ-031 ld_rsp_ready held low 3 cycles -> ld_rsp_data stable, rom_a unchanged, both req_ready 0; accept on cycle 4 with a pending fetch -> fetch accepted the same cycle.
REQ-032 ld addr 0x400 -> ld_rsp_err 1, data 0; ld addr 0x6 -> err 1; if addr 0x3FC -> err 0.
REQ-033 RST_N low during RESP -> rsp_valid 0 immediately (asynchronous); after release there is no stale response and a new request is served normally.
